// File: rtl/fnf_exerciser.sv
// On-chip exerciser for the registered NAND cell: drives vectors, checks OutputPad against a golden pipeline.
// Define FNF_EXERCISER_LFSR_EN to source stimulus from an 8-bit LFSR instead of a 2-bit counter.
module fnf_exerciser #(
    parameter int NUM_VECTORS = 256,
    parameter int LATENCY     = 3,
    parameter int COUNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               OutputPad,
    output logic               Input1,
    output logic               Input2,
    output logic               Busy,
    output logic               Done,
    output logic               Pass,
    output logic [COUNT_W-1:0] ErrorCount,
    output logic [COUNT_W-1:0] VectorCount
);

    localparam int IDX_W = ($clog2(NUM_VECTORS + 1) < 2) ? 2 : $clog2(NUM_VECTORS + 1);
    localparam int DRN_W = ($clog2(LATENCY) < 1) ? 1 : $clog2(LATENCY);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_VECTORS);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               in1_q, in1_d, in2_q, in2_d;
    logic [COUNT_W-1:0] err_q, err_d, vcnt_q, vcnt_d;
    logic [LATENCY-1:0] pv_q, pv_d, pe_q, pe_d;

    logic       start_run;
    logic       drive;
    logic [1:0] vec_bits;

    // idx_q counts vectors already driven; RUN ends on the edge after the last one is driven.
    always_comb begin
        start_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && Start;
        drive     = start_run || ((state_q == S_RUN) && (idx_q != IDX_END));
    end

`ifdef FNF_EXERCISER_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d, lfsr_src;

    always_comb begin
        lfsr_src = start_run ? 8'h01 : lfsr_q;
        vec_bits = lfsr_src[1:0];
        lfsr_d   = lfsr_q;
        if (drive) begin
            lfsr_d = {lfsr_src[6:0], lfsr_src[7] ^ lfsr_src[5] ^ lfsr_src[4] ^ lfsr_src[3]};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        vec_bits = start_run ? 2'b00 : idx_q[1:0];
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        in1_d   = 1'b0;
        in2_d   = 1'b0;
        err_d   = err_q;
        vcnt_d  = vcnt_q;

        pv_d[0] = drive;
        pe_d[0] = ~(vec_bits[1] & vec_bits[0]);
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end

        if (drive) begin
            in1_d  = vec_bits[1];
            in2_d  = vec_bits[0];
            idx_d  = idx_q + IDX_W'(1);
            vcnt_d = vcnt_q + COUNT_W'(1);
        end

        if (pv_q[LATENCY-1] && (OutputPad != pe_q[LATENCY-1]) && (err_q != '1)) begin
            err_d = err_q + COUNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_run) begin
                    state_d = S_RUN;
                    idx_d   = IDX_W'(1);
                    vcnt_d  = COUNT_W'(1);
                    err_d   = '0;
                end
            end
            S_RUN: begin
                if (idx_q == IDX_END) begin
                    state_d = (LATENCY == 1) ? S_DONE : S_DRAIN;
                    drain_d = DRAIN_LAST;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            err_q   <= '0;
            vcnt_q  <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            err_q   <= err_d;
            vcnt_q  <= vcnt_d;
            pv_q    <= pv_d;
        end
    end

    // NOTE: expected bits need no reset; their valid bits gate every compare.
    always_ff @(posedge Clock) begin
        pe_q <= pe_d;
    end

    assign Input1      = in1_q;
    assign Input2      = in2_q;
    assign Busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign Done        = (state_q == S_DONE);
    assign Pass        = Done && (err_q == '0);
    assign ErrorCount  = err_q;
    assign VectorCount = vcnt_q;

endmodule
